// File: rtl/prv664_sb_pkg.sv
// rtl/prv664_sb_pkg.sv - shared sizes and types for the multi-port register scoreboard
package prv664_sb_pkg;

    localparam int SB_NREG = 32;
    localparam int SB_TAGW = 8;
    localparam int SB_IDXW = $clog2(SB_NREG);

    typedef logic [SB_IDXW-1:0] sb_idx_t;

    typedef struct packed {
        logic               busy;
        logic [SB_TAGW-1:0] itag;
    } sb_entry_t;

    function automatic sb_idx_t sb_idx_of(input logic [31:0] value);
        return value[SB_IDXW-1:0];
    endfunction

endpackage

// File: rtl/scoreboard_mp_if.sv
// rtl/scoreboard_mp_if.sv - dispatch/writeback/lookup bundle for scoreboard_mp
interface scoreboard_mp_if #(
    parameter int NREG = 32,
    parameter int TAGW = 8,
    parameter int NWR  = 2,
    parameter int NWB  = 2,
    parameter int NRD  = 4
);
    localparam int IDXW = $clog2(NREG);

    logic                  flush_i;
    logic [NWR-1:0]        disp_write_i;
    logic [NWR*IDXW-1:0]   disp_rdindex_i;
    logic [NWR*TAGW-1:0]   disp_itag_i;
    logic [NWB-1:0]        wb_write_i;
    logic [NWB*IDXW-1:0]   wb_rdindex_i;
    logic [NWB*TAGW-1:0]   wb_itag_i;
    logic [NRD*IDXW-1:0]   rd_index_i;
    logic [NRD-1:0]        rd_busy_o;
    logic [NRD*TAGW-1:0]   rd_itag_o;
    logic [IDXW:0]         busy_cnt_o;
    logic                  all_clear_o;

    modport master (
        output flush_i, disp_write_i, disp_rdindex_i, disp_itag_i,
        output wb_write_i, wb_rdindex_i, wb_itag_i, rd_index_i,
        input  rd_busy_o, rd_itag_o, busy_cnt_o, all_clear_o
    );

    modport slave (
        input  flush_i, disp_write_i, disp_rdindex_i, disp_itag_i,
        input  wb_write_i, wb_rdindex_i, wb_itag_i, rd_index_i,
        output rd_busy_o, rd_itag_o, busy_cnt_o, all_clear_o
    );

endinterface

// File: rtl/scoreboard_entry.sv
// rtl/scoreboard_entry.sv - one scoreboard register: busy bit, producer tag, writeback tag compare
module scoreboard_entry #(
    parameter int TAGW      = 8,
    parameter int NWB       = 2,
    parameter bit HARDWIRED = 1'b0
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              flush_i,
    input  logic              set_i,
    input  logic [TAGW-1:0]   newtag_i,
    input  logic [NWB-1:0]    clr_sel_i,
    input  logic [NWB*TAGW-1:0] wb_itag_i,
    output logic              busy_o,
    output logic [TAGW-1:0]   itag_o,
    output logic              clr_o,
    output logic              busy_d_o
);
    logic            busy_q, busy_d;
    logic [TAGW-1:0] itag_q, itag_d;
    logic            tag_hit;
    logic            set_eff;

    // A hardwired entry never accepts a dispatch, so it stays at its reset value forever.
    assign set_eff = set_i && !HARDWIRED;

    always_comb begin
        tag_hit = 1'b0;
        for (int j = 0; j < NWB; j++) begin
            if (clr_sel_i[j] && (wb_itag_i[j*TAGW +: TAGW] == itag_q)) begin
                tag_hit = 1'b1;
            end
        end
    end

    assign clr_o = busy_q && tag_hit;

    always_comb begin
        busy_d = busy_q;
        itag_d = itag_q;
        if (flush_i) begin
            busy_d = 1'b0;
        end else if (set_eff) begin
            busy_d = 1'b1;
            itag_d = newtag_i;
        end else if (clr_o) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            busy_q <= 1'b0;
            itag_q <= '0;
        end else begin
            busy_q <= busy_d;
            itag_q <= itag_d;
        end
    end

    assign busy_o   = busy_q;
    assign itag_o   = itag_q;
    assign busy_d_o = busy_d;

endmodule

// File: rtl/scoreboard_mp.sv
// rtl/scoreboard_mp.sv - multi-port register scoreboard: dispatch sets, writeback clears, lookups with wb bypass
module scoreboard_mp
    import prv664_sb_pkg::*;
#(
    parameter int NREG           = SB_NREG,
    parameter int TAGW           = SB_TAGW,
    parameter int NWR            = 2,
    parameter int NWB            = 2,
    parameter int NRD            = 4,
    parameter bit ZERO_HARDWIRED = 1'b1
) (
    input  logic            clk_i,
    input  logic            srst_i,
    scoreboard_mp_if.slave  sb
);
    localparam int IDXW = $clog2(NREG);
    localparam int CNTW = IDXW + 1;

    logic [NREG-1:0]      busy;
    logic [NREG-1:0]      busy_next;
    logic [NREG-1:0]      clr_hit;
    logic [TAGW-1:0]      itag [NREG];

    logic [CNTW-1:0]      busy_cnt_q, busy_cnt_d;
    logic                 all_clear_q;

    for (genvar e = 0; e < NREG; e++) begin : g_ent
        logic            set;
        logic [TAGW-1:0] newtag;
        logic [NWB-1:0]  wb_sel;

        // Later ports overwrite earlier ones so the youngest dispatch supplies the tag.
        always_comb begin
            set    = 1'b0;
            newtag = '0;
            for (int p = 0; p < NWR; p++) begin
                if (sb.disp_write_i[p] && (sb.disp_rdindex_i[p*IDXW +: IDXW] == IDXW'(e))) begin
                    set    = 1'b1;
                    newtag = sb.disp_itag_i[p*TAGW +: TAGW];
                end
            end
            for (int j = 0; j < NWB; j++) begin
                wb_sel[j] = sb.wb_write_i[j] && (sb.wb_rdindex_i[j*IDXW +: IDXW] == IDXW'(e));
            end
        end

        scoreboard_entry #(
            .TAGW      (TAGW),
            .NWB       (NWB),
            .HARDWIRED (ZERO_HARDWIRED && (e == 0))
        ) u_entry (
            .clk_i     (clk_i),
            .srst_i    (srst_i),
            .flush_i   (sb.flush_i),
            .set_i     (set),
            .newtag_i  (newtag),
            .clr_sel_i (wb_sel),
            .wb_itag_i (sb.wb_itag_i),
            .busy_o    (busy[e]),
            .itag_o    (itag[e]),
            .clr_o     (clr_hit[e]),
            .busy_d_o  (busy_next[e])
        );
    end

    // Same-cycle matching writeback hides busy; same-cycle dispatch only shows next cycle.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            sb.rd_busy_o[k]              = busy[sb.rd_index_i[k*IDXW +: IDXW]]
                                           && !clr_hit[sb.rd_index_i[k*IDXW +: IDXW]];
            sb.rd_itag_o[k*TAGW +: TAGW] = itag[sb.rd_index_i[k*IDXW +: IDXW]];
        end
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + CNTW'(busy_next[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            busy_cnt_q  <= '0;
            all_clear_q <= 1'b1;
        end else begin
            busy_cnt_q  <= busy_cnt_d;
            all_clear_q <= (busy_cnt_d == '0);
        end
    end

    assign sb.busy_cnt_o  = busy_cnt_q;
    assign sb.all_clear_o = all_clear_q;

endmodule

// File: tb/tb_scoreboard_mp.sv
// tb/tb_scoreboard_mp.sv - directed self-checking bench for scoreboard_mp
module tb_scoreboard_mp;
    localparam int NREG = 32;
    localparam int TAGW = 8;
    localparam int IDXW = 5;
    localparam int NWR  = 2;
    localparam int NWB  = 2;
    localparam int NRD  = 4;

    logic clk = 1'b0;
    logic srst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    scoreboard_mp_if #(.NREG(NREG), .TAGW(TAGW), .NWR(NWR), .NWB(NWB), .NRD(NRD)) sb0 ();
    scoreboard_mp_if #(.NREG(NREG), .TAGW(TAGW), .NWR(NWR), .NWB(NWB), .NRD(NRD)) sb1 ();

    scoreboard_mp #(.NREG(NREG), .TAGW(TAGW), .NWR(NWR), .NWB(NWB), .NRD(NRD), .ZERO_HARDWIRED(1'b1))
        u_dut0 (.clk_i(clk), .srst_i(srst), .sb(sb0.slave));
    scoreboard_mp #(.NREG(NREG), .TAGW(TAGW), .NWR(NWR), .NWB(NWB), .NRD(NRD), .ZERO_HARDWIRED(1'b0))
        u_dut1 (.clk_i(clk), .srst_i(srst), .sb(sb1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sb0.flush_i = 1'b0; sb0.disp_write_i = '0; sb0.wb_write_i = '0;
        sb0.disp_rdindex_i = '0; sb0.disp_itag_i = '0; sb0.wb_rdindex_i = '0; sb0.wb_itag_i = '0;
        sb1.flush_i = 1'b0; sb1.disp_write_i = '0; sb1.wb_write_i = '0;
        sb1.disp_rdindex_i = '0; sb1.disp_itag_i = '0; sb1.wb_rdindex_i = '0; sb1.wb_itag_i = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic disp0(input int port, input int idx, input int tag);
        sb0.disp_write_i[port] = 1'b1;
        sb0.disp_rdindex_i[port*IDXW +: IDXW] = IDXW'(idx);
        sb0.disp_itag_i[port*TAGW +: TAGW] = TAGW'(tag);
    endtask

    task automatic wb0(input int port, input int idx, input int tag);
        sb0.wb_write_i[port] = 1'b1;
        sb0.wb_rdindex_i[port*IDXW +: IDXW] = IDXW'(idx);
        sb0.wb_itag_i[port*TAGW +: TAGW] = TAGW'(tag);
    endtask

    task automatic look0(input int port, input int idx);
        sb0.rd_index_i[port*IDXW +: IDXW] = IDXW'(idx);
        #1;
    endtask

    initial begin
        idle();
        sb0.rd_index_i = '0;
        sb1.rd_index_i = '0;
        srst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        sb0.rd_index_i = {5'd31, 5'd17, 5'd5, 5'd0};
        #1;
        chk("rst_busy",      32'(sb0.rd_busy_o), 32'h0);
        chk("rst_itag",      32'(sb0.rd_itag_o), 32'h0);
        chk("rst_cnt",       32'(sb0.busy_cnt_o), 32'd0);
        chk("rst_clear",     32'(sb0.all_clear_o), 32'd1);
        chk("rst_clear_fp",  32'(sb1.all_clear_o), 32'd1);
        srst = 1'b0;

        // basic dispatch then writeback with same-cycle bypass
        disp0(0, 5, 8'h12);
        look0(0, 5);
        chk("no_disp_bypass", 32'(sb0.rd_busy_o[0]), 32'd0);
        step();
        chk("x5_busy", 32'(sb0.rd_busy_o[0]), 32'd1);
        chk("x5_itag", 32'(sb0.rd_itag_o[7:0]), 32'h12);
        chk("x5_cnt",  32'(sb0.busy_cnt_o), 32'd1);
        chk("x5_nclr", 32'(sb0.all_clear_o), 32'd0);
        wb0(0, 5, 8'h12);
        #1;
        chk("x5_wb_bypass", 32'(sb0.rd_busy_o[0]), 32'd0);
        step();
        chk("x5_rel_busy", 32'(sb0.rd_busy_o[0]), 32'd0);
        chk("x5_rel_cnt",  32'(sb0.busy_cnt_o), 32'd0);

        // stale writeback after re-dispatch
        disp0(0, 7, 8'h01); step();
        disp0(1, 7, 8'h02); step();
        look0(0, 7);
        wb0(0, 7, 8'h01);
        #1;
        chk("x7_stale_bypass", 32'(sb0.rd_busy_o[0]), 32'd1);
        step();
        chk("x7_busy", 32'(sb0.rd_busy_o[0]), 32'd1);
        chk("x7_itag", 32'(sb0.rd_itag_o[7:0]), 32'h02);
        chk("x7_cnt",  32'(sb0.busy_cnt_o), 32'd1);
        wb0(1, 7, 8'h02); step();
        chk("x7_free_cnt", 32'(sb0.busy_cnt_o), 32'd0);

        // same-cycle dispatch conflict, then dispatch racing a matching writeback
        disp0(0, 3, 8'h10); disp0(1, 3, 8'h11); step();
        look0(1, 3);
        chk("x3_young_itag", 32'(sb0.rd_itag_o[15:8]), 32'h11);
        chk("x3_cnt",        32'(sb0.busy_cnt_o), 32'd1);
        disp0(0, 3, 8'h20); wb0(0, 3, 8'h11); step();
        chk("x3_redisp_busy", 32'(sb0.rd_busy_o[1]), 32'd1);
        chk("x3_redisp_itag", 32'(sb0.rd_itag_o[15:8]), 32'h20);
        chk("x3_redisp_cnt",  32'(sb0.busy_cnt_o), 32'd1);
        wb0(1, 3, 8'h20); step();

        // two writebacks to one index, only the second tag matches
        disp0(0, 4, 8'h40); step();
        look0(2, 4);
        wb0(0, 4, 8'h99); wb0(1, 4, 8'h40);
        #1;
        chk("x4_dualwb_bypass", 32'(sb0.rd_busy_o[2]), 32'd0);
        step();
        chk("x4_dualwb_busy", 32'(sb0.rd_busy_o[2]), 32'd0);
        chk("x4_dualwb_cnt",  32'(sb0.busy_cnt_o), 32'd0);

        // register zero: hardwired vs FP file
        disp0(0, 0, 8'h33);
        sb1.disp_write_i[0] = 1'b1; sb1.disp_rdindex_i[4:0] = 5'd0; sb1.disp_itag_i[7:0] = 8'h33;
        step();
        look0(0, 0);
        sb1.rd_index_i = '0;
        #1;
        chk("x0_hw_busy",  32'(sb0.rd_busy_o[0]), 32'd0);
        chk("x0_hw_itag",  32'(sb0.rd_itag_o[7:0]), 32'h0);
        chk("x0_hw_cnt",   32'(sb0.busy_cnt_o), 32'd0);
        chk("x0_fp_busy",  32'(sb1.rd_busy_o[0]), 32'd1);
        chk("x0_fp_itag",  32'(sb1.rd_itag_o[7:0]), 32'h33);
        chk("x0_fp_cnt",   32'(sb1.busy_cnt_o), 32'd1);

        // fill x1..x31, then flush with a concurrent dispatch
        for (int c = 0; c < 16; c++) begin
            disp0(0, 2*c + 1, 2*c + 1);
            if (2*c + 2 <= 31) disp0(1, 2*c + 2, 2*c + 2);
            step();
        end
        look0(3, 31);
        look0(1, 9);
        chk("fill_cnt",    32'(sb0.busy_cnt_o), 32'd31);
        chk("fill_nclr",   32'(sb0.all_clear_o), 32'd0);
        chk("fill_x31",    32'(sb0.rd_itag_o[31:24]), 32'd31);
        chk("fill_x9",     32'(sb0.rd_busy_o[1]), 32'd1);
        sb0.flush_i = 1'b1;
        disp0(0, 9, 8'h55);
        step();
        chk("flush_cnt",   32'(sb0.busy_cnt_o), 32'd0);
        chk("flush_clear", 32'(sb0.all_clear_o), 32'd1);
        chk("flush_x9",    32'(sb0.rd_busy_o[1]), 32'd0);
        chk("flush_x31",   32'(sb0.rd_busy_o[3]), 32'd0);

        // reset wins over a same-cycle dispatch
        disp0(0, 6, 8'h66);
        srst = 1'b1;
        step();
        srst = 1'b0;
        look0(0, 6);
        chk("rst_mid_busy", 32'(sb0.rd_busy_o[0]), 32'd0);
        chk("rst_mid_itag", 32'(sb0.rd_itag_o[7:0]), 32'h0);
        chk("rst_mid_cnt",  32'(sb0.busy_cnt_o), 32'd0);
        chk("rst_mid_fp",   32'(sb1.busy_cnt_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
